// File: rtl/adc_capture_ctrl_if.sv
// Capture control bus: arm/abort/trigger controls, ADC frame stream in, capture buffer write port out.
// master drives controls and frames; slave is the capture controller.
interface adc_capture_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              START;
  logic              ABORT;
  logic              SRC_SEL;
  logic [ADDR_W-1:0] FRAME_NUM;
  logic              SW_TRIG;
  logic [8:0]        TRIG_LEVEL;
  logic              FRAME_VALID;
  logic [8:0]        SAMPLE0;
  logic              MEM_READY;

  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_SEL;
  logic              BUSY;
  logic              DONE;
  logic [7:0]        DROP_CNT;

  modport master (
    output START, ABORT, SRC_SEL, FRAME_NUM, SW_TRIG, TRIG_LEVEL,
           FRAME_VALID, SAMPLE0, MEM_READY,
    input  MEM_WE, MEM_ADDR, MEM_SEL, BUSY, DONE, DROP_CNT
  );

  modport slave (
    input  START, ABORT, SRC_SEL, FRAME_NUM, SW_TRIG, TRIG_LEVEL,
           FRAME_VALID, SAMPLE0, MEM_READY,
    output MEM_WE, MEM_ADDR, MEM_SEL, BUSY, DONE, DROP_CNT
  );
endinterface

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: arm, trigger, then write FRAME_NUM frames to the buffer (write strobe 1 cycle after accept; frames dropped and counted while MEM_READY low).
// Optional level trigger on channel-0 rising crossing of TRIG_LEVEL when ADC_CAPTURE_LEVEL_TRIG_EN is defined.
module adc_capture_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              ADC_CLK500M,
  input  logic              RESET,
  adc_capture_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t            state;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_sel;
  logic [7:0]        drop_cnt;
  // One bit wider than the address so a FRAME_NUM of 0 can hold 2**ADDR_W.
  logic [ADDR_W:0]   frame_idx;
  logic [ADDR_W:0]   target;
  logic [ADDR_W:0]   idx_next;
  logic              arm_req;
  logic              trig;

  assign idx_next = frame_idx + 1'b1;
  assign arm_req  = bus.START && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
  logic       hist_vld;
  logic [8:0] hist_sample;
  logic       level_cross;

  assign level_cross = bus.FRAME_VALID && hist_vld &&
                       (hist_sample < bus.TRIG_LEVEL) &&
                       (bus.SAMPLE0 >= bus.TRIG_LEVEL);
  assign trig = bus.SW_TRIG || level_cross;

  // History only follows frames seen while ARMED; a fresh arm starts empty.
  always_ff @(posedge ADC_CLK500M) begin
    if (RESET) begin
      hist_vld    <= 1'b0;
      hist_sample <= '0;
    end else if (bus.ABORT || arm_req) begin
      hist_vld    <= 1'b0;
    end else if ((state == ST_ARMED) && bus.FRAME_VALID) begin
      hist_vld    <= 1'b1;
      hist_sample <= bus.SAMPLE0;
    end
  end
`else
  logic unused_level;

  assign unused_level = ^{bus.TRIG_LEVEL, bus.SAMPLE0};
  assign trig         = bus.SW_TRIG;
`endif

  always_ff @(posedge ADC_CLK500M) begin
    if (RESET) begin
      state     <= ST_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_sel   <= 1'b0;
      drop_cnt  <= '0;
      frame_idx <= '0;
      target    <= '0;
    end else begin
      mem_we <= 1'b0;
      if (bus.ABORT) begin
        state <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE, ST_DONE: begin
            if (bus.START) begin
              state     <= ST_ARMED;
              mem_sel   <= bus.SRC_SEL;
              target    <= {(bus.FRAME_NUM == '0), bus.FRAME_NUM};
              drop_cnt  <= '0;
              frame_idx <= '0;
            end
          end
          ST_ARMED: begin
            // The frame present in the trigger cycle is not captured.
            if (trig) begin
              state <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (bus.FRAME_VALID) begin
              if (bus.MEM_READY) begin
                mem_we    <= 1'b1;
                mem_addr  <= frame_idx[ADDR_W-1:0];
                frame_idx <= idx_next;
                if (idx_next == target) begin
                  state <= ST_DONE;
                end
              end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.MEM_WE   = mem_we;
  assign bus.MEM_ADDR = mem_addr;
  assign bus.MEM_SEL  = mem_sel;
  assign bus.DROP_CNT = drop_cnt;
  assign bus.BUSY     = (state == ST_ARMED) || (state == ST_CAPTURE);
  assign bus.DONE     = (state == ST_DONE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed and randomized checks of adc_capture_ctrl against a transaction-level model of capture runs.
`timescale 1ns/100ps
module tb_adc_capture_ctrl;
  localparam int AW = 4;

  logic ADC_CLK500M = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;
  logic [AW-1:0] model_addr = '0;

  adc_capture_ctrl_if #(.ADDR_W(AW)) bus ();
  adc_capture_ctrl #(.ADDR_W(AW)) dut (
    .ADC_CLK500M (ADC_CLK500M),
    .RESET       (RESET),
    .bus         (bus)
  );

  always #1 ADC_CLK500M = ~ADC_CLK500M;

  task automatic tick();
    @(posedge ADC_CLK500M);
    #0.2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    bus.START       = 1'b0;
    bus.ABORT       = 1'b0;
    bus.SRC_SEL     = 1'b0;
    bus.FRAME_NUM   = '0;
    bus.SW_TRIG     = 1'b0;
    bus.TRIG_LEVEL  = 9'h100;
    bus.FRAME_VALID = 1'b0;
    bus.SAMPLE0     = '0;
    bus.MEM_READY   = 1'b1;
  endtask

  task automatic arm(input logic [AW-1:0] fnum, input logic src);
    bus.START       = 1'b1;
    bus.SRC_SEL     = src;
    bus.FRAME_NUM   = fnum;
    bus.FRAME_VALID = 1'($urandom_range(0, 1));
    tick();
    bus.START     = 1'b0;
    bus.SRC_SEL   = ~src;
    bus.FRAME_NUM = AW'($urandom);
    chk("arm_busy", 32'(bus.BUSY), 32'(1));
    chk("arm_done", 32'(bus.DONE), 32'(0));
    chk("arm_sel", 32'(bus.MEM_SEL), 32'(src));
    chk("arm_drop", 32'(bus.DROP_CNT), 32'(0));
    chk("arm_we", 32'(bus.MEM_WE), 32'(0));
    chk("arm_addr", 32'(bus.MEM_ADDR), 32'(model_addr));
  endtask

  task automatic armed_wait(input int n);
    for (int i = 0; i < n; i++) begin
      bus.FRAME_VALID = 1'($urandom_range(0, 1));
      bus.MEM_READY   = 1'($urandom_range(0, 1));
      bus.SAMPLE0     = 9'($urandom_range(0, 255));
      tick();
      chk("armed_busy", 32'(bus.BUSY), 32'(1));
      chk("armed_we", 32'(bus.MEM_WE), 32'(0));
    end
  endtask

  task automatic trigger();
    bus.SW_TRIG     = 1'b1;
    bus.FRAME_VALID = 1'b1;
    bus.MEM_READY   = 1'b1;
    bus.SAMPLE0     = '0;
    tick();
    bus.SW_TRIG = 1'b0;
    chk("trig_frame_skipped", 32'(bus.MEM_WE), 32'(0));
    chk("trig_busy", 32'(bus.BUSY), 32'(1));
  endtask

  // mode 0: continuous, 1: random with ignored STARTs, 2: two drops after first frame, 3: 300 drops first
  task automatic capture(input logic [AW-1:0] fnum, input logic src, input int mode);
    int acc   = 0;
    int drops = 0;
    int cyc   = 0;
    int tgt   = (fnum == 0) ? (1 << AW) : int'(fnum);
    while (acc < tgt && cyc < 2000) begin
      logic v, r, we_exp;
      case (mode)
        0:       begin v = 1'b1; r = 1'b1; end
        1:       begin v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 2) != 0); end
        2:       begin v = 1'b1; r = !(cyc == 1 || cyc == 2); end
        default: begin v = 1'b1; r = (cyc >= 300); end
      endcase
      bus.FRAME_VALID = v;
      bus.MEM_READY   = r;
      bus.START       = (mode == 1) && ($urandom_range(0, 7) == 0);
      bus.FRAME_NUM   = AW'($urandom);
      bus.SRC_SEL     = 1'($urandom_range(0, 1));
      tick();
      if (v && r) begin
        we_exp     = 1'b1;
        model_addr = AW'(acc);
        acc++;
      end else begin
        we_exp = 1'b0;
        if (v) drops = (drops < 255) ? drops + 1 : 255;
      end
      chk("cap_we", 32'(bus.MEM_WE), 32'(we_exp));
      chk("cap_addr", 32'(bus.MEM_ADDR), 32'(model_addr));
      chk("cap_drop", 32'(bus.DROP_CNT), 32'(drops));
      chk("cap_done", 32'(bus.DONE), 32'(acc == tgt));
      chk("cap_busy", 32'(bus.BUSY), 32'(acc != tgt));
      chk("cap_sel", 32'(bus.MEM_SEL), 32'(src));
      cyc++;
    end
    bus.START = 1'b0;
    chk("cap_complete", 32'(acc), 32'(tgt));
  endtask

  task automatic done_hold(input int n);
    for (int i = 0; i < n; i++) begin
      bus.FRAME_VALID = 1'b1;
      bus.MEM_READY   = 1'b1;
      bus.SW_TRIG     = 1'($urandom_range(0, 1));
      tick();
      chk("done_hold_we", 32'(bus.MEM_WE), 32'(0));
      chk("done_hold_done", 32'(bus.DONE), 32'(1));
      chk("done_hold_addr", 32'(bus.MEM_ADDR), 32'(model_addr));
    end
    bus.SW_TRIG = 1'b0;
  endtask

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
  task automatic level_frame(input logic [8:0] s);
    bus.FRAME_VALID = 1'b1;
    bus.MEM_READY   = 1'b1;
    bus.SAMPLE0     = s;
    tick();
    chk("level_no_capture", 32'(bus.MEM_WE), 32'(0));
    chk("level_busy", 32'(bus.BUSY), 32'(1));
  endtask
`endif

  initial begin
    idle_inputs();
    RESET = 1'b1;
    tick();
    tick();
    chk("rst_we", 32'(bus.MEM_WE), 32'(0));
    chk("rst_addr", 32'(bus.MEM_ADDR), 32'(0));
    chk("rst_sel", 32'(bus.MEM_SEL), 32'(0));
    chk("rst_drop", 32'(bus.DROP_CNT), 32'(0));
    chk("rst_busy", 32'(bus.BUSY), 32'(0));
    chk("rst_done", 32'(bus.DONE), 32'(0));
    RESET = 1'b0;
    tick();

    // Four continuous frames.
    arm(4, 1'b1);
    armed_wait(3);
    trigger();
    capture(4, 1'b1, 0);
    done_hold(2);

    // Two drops mid-capture of three frames.
    arm(3, 1'b0);
    armed_wait(1);
    trigger();
    capture(3, 1'b0, 2);
    chk("drop_two", 32'(bus.DROP_CNT), 32'(2));

    // ABORT with START in CAPTURE, then re-arm.
    arm(8, 1'b0);
    trigger();
    bus.FRAME_VALID = 1'b1;
    bus.MEM_READY   = 1'b1;
    tick();
    model_addr = '0;
    chk("abort_pre_we", 32'(bus.MEM_WE), 32'(1));
    bus.MEM_READY = 1'b0;
    tick();
    chk("abort_pre_drop", 32'(bus.DROP_CNT), 32'(1));
    bus.ABORT     = 1'b1;
    bus.START     = 1'b1;
    bus.SW_TRIG   = 1'b1;
    bus.MEM_READY = 1'b1;
    tick();
    bus.ABORT   = 1'b0;
    bus.START   = 1'b0;
    bus.SW_TRIG = 1'b0;
    chk("abort_busy", 32'(bus.BUSY), 32'(0));
    chk("abort_done", 32'(bus.DONE), 32'(0));
    chk("abort_we", 32'(bus.MEM_WE), 32'(0));
    tick();
    chk("abort_idle_we", 32'(bus.MEM_WE), 32'(0));
    chk("abort_idle_busy", 32'(bus.BUSY), 32'(0));
    arm(2, 1'b1);
    trigger();
    capture(2, 1'b1, 0);

    // Full-depth capture and drop counter saturation.
    arm(0, 1'b1);
    trigger();
    capture(0, 1'b1, 0);
    arm(1, 1'b0);
    trigger();
    capture(1, 1'b0, 3);
    chk("drop_saturated", 32'(bus.DROP_CNT), 32'(255));

    for (int run = 0; run < 6; run++) begin
      logic [AW-1:0] fn;
      logic          src;
      fn  = AW'($urandom);
      src = 1'($urandom_range(0, 1));
      arm(fn, src);
      armed_wait($urandom_range(0, 4));
      trigger();
      capture(fn, src, 1);
      done_hold(1);
    end

`ifdef ADC_CAPTURE_LEVEL_TRIG_EN
    bus.TRIG_LEVEL = 9'h100;
    arm(1, 1'b0);
    level_frame(9'h0F0);
    level_frame(9'h0F8);
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    chk("level_abort_busy", 32'(bus.BUSY), 32'(0));
    arm(1, 1'b0);
    level_frame(9'h120);
    level_frame(9'h130);
    level_frame(9'h0F0);
    level_frame(9'h0F8);
    level_frame(9'h110);
    bus.SAMPLE0 = 9'h000;
    tick();
    model_addr = '0;
    chk("level_cap_we", 32'(bus.MEM_WE), 32'(1));
    chk("level_cap_addr", 32'(bus.MEM_ADDR), 32'(0));
    chk("level_cap_done", 32'(bus.DONE), 32'(1));
`endif

    // RESET mid-capture beats START.
    arm(5, 1'b1);
    trigger();
    bus.FRAME_VALID = 1'b1;
    bus.MEM_READY   = 1'b1;
    tick();
    tick();
    chk("rst_mid_pre_addr", 32'(bus.MEM_ADDR), 32'(1));
    RESET     = 1'b1;
    bus.START = 1'b1;
    tick();
    RESET     = 1'b0;
    bus.START = 1'b0;
    model_addr = '0;
    chk("rst_mid_we", 32'(bus.MEM_WE), 32'(0));
    chk("rst_mid_addr", 32'(bus.MEM_ADDR), 32'(0));
    chk("rst_mid_sel", 32'(bus.MEM_SEL), 32'(0));
    chk("rst_mid_drop", 32'(bus.DROP_CNT), 32'(0));
    chk("rst_mid_busy", 32'(bus.BUSY), 32'(0));
    chk("rst_mid_done", 32'(bus.DONE), 32'(0));
    bus.SW_TRIG = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_trig_busy", 32'(bus.BUSY), 32'(0));
      chk("idle_trig_we", 32'(bus.MEM_WE), 32'(0));
    end
    bus.SW_TRIG = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 SHALL have parameter: ADDR_W, default 12, capture buffer address width (frames per capture up to 2**ADDR_W).
REQ-002 SHALL have port: ADC_CLK500M  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port: RESET  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: START  input  1  arm request, single-cycle pulse.
REQ-005 SHALL have port: ABORT  input  1  return to IDLE from any state.
REQ-006 SHALL have port: SRC_SEL  input  1  source for MEM_SEL: 0 = TI96 bank, 1 = TI48 bank.
REQ-007 SHALL have port: FRAME_NUM  input  ADDR_W  frames to capture; 0 means 2**ADDR_W.
REQ-008 SHALL have port: SW_TRIG  input  1  software trigger.
REQ-009 SHALL have port: TRIG_LEVEL  input  9  level-trigger threshold, unsigned offset-binary.
REQ-010 SHALL have port: FRAME_VALID  input  1  one full ADC frame present this cycle.
REQ-011 SHALL have port: SAMPLE0  input  9  channel-0 sample of the current frame.
REQ-012 SHALL have port: MEM_READY  input  1  buffer can accept a write this cycle.
REQ-013 SHALL have port: MEM_WE  output  1  buffer write strobe.
REQ-014 SHALL have port: MEM_ADDR  output  ADDR_W  buffer frame address.
REQ-015 SHALL have port: MEM_SEL  output  1  SRC_SEL value latched at arm.
REQ-016 SHALL have port: BUSY  output  1  high in ARMED or CAPTURE.
REQ-017 SHALL have port: DONE  output  1  high in DONE state.
REQ-018 SHALL have port: DROP_CNT  output  8  frames dropped for MEM_READY low, saturating.

Function
REQ-019 SHALL implement states IDLE, ARMED, CAPTURE, DONE; BUSY and DONE decode state combinationally.
REQ-020 SHALL, on START in IDLE or DONE, enter ARMED next cycle and latch SRC_SEL into MEM_SEL and FRAME_NUM into the target count; clear DROP_CNT and the frame index.
REQ-021 SHALL ignore START in ARMED or CAPTURE.
REQ-022 SHALL, on ABORT in any state, enter IDLE next cycle with MEM_WE 0; ABORT wins over simultaneous START or trigger.
REQ-023 SHALL, in ARMED, enter CAPTURE the cycle after a trigger event; the frame present in the trigger cycle is not captured.
REQ-024 SHALL, in CAPTURE, accept a frame when FRAME_VALID=1 and MEM_READY=1: next cycle MEM_WE=1, MEM_ADDR=frame index, index increments.
REQ-025 SHALL hold MEM_WE at 0 in every cycle not following an accepted frame (latency exactly 1 cycle).
REQ-026 SHALL, in CAPTURE, when FRAME_VALID=1 and MEM_READY=0, drop the frame, not advance the index, increment DROP_CNT saturating at 255.
REQ-027 SHALL enter DONE the cycle after the accept that brings the count to target; MEM_WE for that last frame coincides with the first DONE cycle.
REQ-028 SHALL stay in DONE until START or ABORT; frames in IDLE and DONE are ignored.
REQ-029 SHALL hold MEM_ADDR at its last written value when not writing; index counts 0..target-1 with no wrap.

Reset
REQ-030 SHALL, on RESET, enter IDLE with MEM_WE=0, MEM_ADDR=0, MEM_SEL=0, DROP_CNT=0, index=0, trigger history cleared.
REQ-031 SHALL give RESET priority over ABORT, START and all other inputs, including mid-capture.

Configuration
REQ-032 SHALL, with ADC_CAPTURE_LEVEL_TRIG_EN defined, treat as trigger SW_TRIG or a rising crossing: in ARMED, FRAME_VALID=1, previous ARMED frame's SAMPLE0 < TRIG_LEVEL and current SAMPLE0 >= TRIG_LEVEL.
REQ-033 SHALL clear the crossing history on entering ARMED so the first ARMED frame never triggers by level.
REQ-034 SHALL, without ADC_CAPTURE_LEVEL_TRIG_EN, trigger on SW_TRIG only; TRIG_LEVEL and SAMPLE0 are unused and no history register exists.

Verification
REQ-035 SHALL cover: RESET, START, SW_TRIG, FRAME_NUM=4, FRAME_VALID and MEM_READY continuous -> MEM_WE four cycles, MEM_ADDR 0,1,2,3, DONE on the cycle of the ADDR=3 write.
REQ-036 SHALL cover: FRAME_NUM=3, MEM_READY low for 2 frames mid-capture -> DROP_CNT=2, addresses 0,1,2 contiguous, DONE asserted.
REQ-037 SHALL cover: ABORT and START same cycle during CAPTURE -> IDLE next cycle, MEM_WE 0; following START re-arms with DROP_CNT=0.
REQ-038 SHALL cover: with macro, TRIG_LEVEL=0x100, SAMPLE0 sequence 0x0F0,0x0F8,0x110 -> CAPTURE entered after the 0x110 frame only; first frame 0x120 alone does not trigger.
REQ-039 SHALL cover: FRAME_NUM=0 with ADDR_W=4 -> 16 writes, addresses 0..15; 300 dropped frames -> DROP_CNT=255.
REQ-040 SHALL cover: RESET asserted mid-CAPTURE -> all outputs at reset values next cycle, SW_TRIG in IDLE ignored.
